// File: rtl/stack_port_ctrl.sv
// stack_port_ctrl: sequences load/store/push/pop requests onto a byte-addressed memory with a downward-growing stack
module stack_port_ctrl #(
   parameter logic [15:0] STACK_TOP   = 16'd62,
   parameter logic [15:0] STACK_LIMIT = 16'd32
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic [1:0]  Op,
   input  logic [15:0] ReqAddr,
   input  logic [15:0] WrData,
   output logic        Ack,
   output logic        Err,
   output logic [15:0] RdData,
   output logic        Busy,
   output logic        Full,
   output logic        Empty,
   output logic        MemRW,
   output logic        PushControl,
   output logic        PopControl,
   output logic [15:0] CurrentSP,
   output logic [15:0] Addr,
   output logic [15:0] DataIn,
   input  logic [15:0] DataOut
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_PUSH = 2'b10, OP_POP = 2'b11;
   state_t state, state_n;
   logic [15:0] sp;
   logic [1:0]  op_q;
   logic        accept, illegal;
   assign Full      = sp < STACK_LIMIT;
   assign Empty     = sp == STACK_TOP;
   assign Busy      = state != IDLE;
   assign Ack       = state == DONE;
   assign CurrentSP = sp;
   assign accept    = state == IDLE && Req;
   assign illegal   = (Op == OP_PUSH && Full) || (Op == OP_POP && Empty);
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = accept ? (illegal ? DONE : ACCESS) : (state == ACCESS) ? DONE : IDLE;
   end
   // request fields are folded into the memory-side registers at acceptance, so later input changes cannot leak in
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sp          <= STACK_TOP;
         op_q        <= OP_LOAD;
         Err         <= 1'b0;
         RdData      <= '0;
         MemRW       <= 1'b0;
         PushControl <= 1'b0;
         PopControl  <= 1'b0;
         Addr        <= '0;
         DataIn      <= '0;
      end else begin
         if (accept) begin
            op_q <= Op;
            Err  <= illegal;
            if (!illegal) begin
               MemRW       <= Op == OP_STORE || Op == OP_PUSH;
               PushControl <= Op == OP_PUSH;
               PopControl  <= Op == OP_POP;
               Addr        <= (Op == OP_PUSH) ? WrData : ReqAddr;
               DataIn      <= (Op == OP_STORE) ? WrData : DataIn;
            end
         end
         if (state == ACCESS) begin
            MemRW       <= 1'b0;
            PushControl <= 1'b0;
            PopControl  <= 1'b0;
            RdData      <= (op_q == OP_LOAD) ? DataOut : (op_q == OP_POP) ? {DataOut[7:0], DataOut[15:8]} : RdData;
            sp          <= (op_q == OP_PUSH) ? sp - 16'd2 : (op_q == OP_POP) ? sp + 16'd2 : sp;
         end
      end
   end
endmodule

// File: tb/tb_stack_port_ctrl.sv
// tb_stack_port_ctrl: scoreboard bench with a byte memory model for stack_port_ctrl
module tb_stack_port_ctrl;
   logic        Clk = 1'b0, Rst_n = 1'b1, Req = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [15:0] ReqAddr = '0, WrData = '0, DataOut;
   logic        Ack, Err, Busy, Full, Empty, MemRW, PushControl, PopControl;
   logic [15:0] RdData, CurrentSP, Addr, DataIn;

   stack_port_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Op(Op), .ReqAddr(ReqAddr), .WrData(WrData),
      .Ack(Ack), .Err(Err), .RdData(RdData), .Busy(Busy), .Full(Full), .Empty(Empty),
      .MemRW(MemRW), .PushControl(PushControl), .PopControl(PopControl),
      .CurrentSP(CurrentSP), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut)
   );

   always #5 Clk = ~Clk;

   // byte memory: pushes store big-endian at SP, loads/stores little-endian at Addr
   logic [7:0]  mem [0:65535];
   logic [15:0] rd_a;
   always_comb begin
      rd_a    = PopControl ? CurrentSP + 16'd2 : Addr;
      DataOut = {mem[rd_a + 16'd1], mem[rd_a]};
   end
   always @(posedge Clk)
      if (MemRW) begin
         if (PushControl) begin
            mem[CurrentSP]         <= Addr[15:8];
            mem[CurrentSP + 16'd1] <= Addr[7:0];
         end else begin
            mem[Addr]         <= DataIn[7:0];
            mem[Addr + 16'd1] <= DataIn[15:8];
         end
      end

   typedef struct {
      logic        err;
      logic [15:0] rd;
      logic [15:0] sp;
      logic [15:0] pre_sp;
      int          lat;
      logic        rw, pu, po;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0, failures = 0;
   logic [15:0] sp_m = 16'd62, rd_m = 16'd0;
   logic [15:0] stk[$];
   logic [15:0] wmem [int];

   task automatic model_reset;
      sp_m = 16'd62;
      rd_m = 16'd0;
      stk.delete();
   endtask

   task automatic do_reset;
      @(negedge Clk);
      Req = 1'b0;
      Rst_n = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      model_reset();
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input bit scramble, input string nm);
      exp_t e, g;
      int lat;
      bit bad;
      logic a_rw, a_pu, a_po, seen;
      logic [15:0] a_sp, a_addr, a_din;
      bad = (op == 2'b10 && sp_m < 16'd32) || (op == 2'b11 && sp_m == 16'd62);
      e.err = bad;
      e.lat = bad ? 1 : 2;
      e.rw = !bad && (op == 2'b01 || op == 2'b10);
      e.pu = !bad && op == 2'b10;
      e.po = !bad && op == 2'b11;
      e.pre_sp = sp_m;
      if (!bad)
         case (op)
            2'b00: rd_m = wmem.exists(int'(addr)) ? wmem[int'(addr)] : 16'd0;
            2'b01: wmem[int'(addr)] = data;
            2'b10: begin stk.push_back(data); sp_m = sp_m - 16'd2; end
            default: begin rd_m = stk.pop_back(); sp_m = sp_m + 16'd2; end
         endcase
      e.rd = rd_m;
      e.sp = sp_m;
      sb.push_back(e);
      @(negedge Clk);
      Req = 1'b1; Op = op; ReqAddr = addr; WrData = data;
      lat = 0; seen = 0; a_rw = 0; a_pu = 0; a_po = 0; a_sp = '0; a_addr = '0; a_din = '0;
      while (lat < 8) begin
         @(negedge Clk);
         lat++;
         seen |= MemRW | PushControl | PopControl;
         if (lat == 1) begin
            a_rw = MemRW; a_pu = PushControl; a_po = PopControl;
            a_sp = CurrentSP; a_addr = Addr; a_din = DataIn;
         end
         if (Ack) break;
         Req = scramble;
         if (scramble) begin
            Op = 2'($urandom);
            ReqAddr = 16'($urandom);
            WrData = 16'($urandom);
         end
      end
      Req = 1'b0;
      g = sb.pop_front();
      checks++; if (lat !== g.lat) begin failures++; $display("FAIL %s latency got %0d want %0d", nm, lat, g.lat); end
      checks++; if (Err !== g.err) begin failures++; $display("FAIL %s err got %b want %b", nm, Err, g.err); end
      checks++; if (RdData !== g.rd) begin failures++; $display("FAIL %s rddata got %h want %h", nm, RdData, g.rd); end
      checks++; if (CurrentSP !== g.sp) begin failures++; $display("FAIL %s sp got %0d want %0d", nm, CurrentSP, g.sp); end
      checks++; if ({a_rw, a_pu, a_po} !== {g.rw, g.pu, g.po})
         begin failures++; $display("FAIL %s rw/push/pop got %b%b%b want %b%b%b", nm, a_rw, a_pu, a_po, g.rw, g.pu, g.po); end
      if (bad) begin
         checks++; if (seen !== 1'b0) begin failures++; $display("FAIL %s memory strobe got %b want 0", nm, seen); end
      end else begin
         if (op != 2'b11) begin
            checks++; if (a_addr !== ((op == 2'b10) ? data : addr))
               begin failures++; $display("FAIL %s addr got %h want %h", nm, a_addr, (op == 2'b10) ? data : addr); end
         end
         if (op[1]) begin
            checks++; if (a_sp !== g.pre_sp) begin failures++; $display("FAIL %s access sp got %0d want %0d", nm, a_sp, g.pre_sp); end
         end
         if (op == 2'b01) begin
            checks++; if (a_din !== data) begin failures++; $display("FAIL %s datain got %h want %h", nm, a_din, data); end
         end
      end
   endtask

   task automatic test_reset;
      #1 Rst_n = 1'b0;
      #1;
      checks++; if ({Busy, Ack, Err, MemRW, PushControl, PopControl, Full, Empty} !== 8'b0000_0001)
         begin failures++; $display("FAIL reset flags got %b want 00000001", {Busy, Ack, Err, MemRW, PushControl, PopControl, Full, Empty}); end
      checks++; if (CurrentSP !== 16'd62) begin failures++; $display("FAIL reset sp got %0d want 62", CurrentSP); end
      checks++; if ({Addr, DataIn, RdData} !== 48'd0)
         begin failures++; $display("FAIL reset data got %h %h %h want 0 0 0", Addr, DataIn, RdData); end
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++; if (Busy !== 1'b0 || CurrentSP !== 16'd62)
         begin failures++; $display("FAIL reset idle busy=%b sp=%0d want 0 62", Busy, CurrentSP); end
      model_reset();
   endtask

   task automatic test_push_pop;
      issue(2'b10, 16'h0000, 16'hA1B2, 1'b0, "push_a1b2");
      checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL push_empty got %b want 0", Empty); end
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "pop_a1b2");
      checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL pop_empty got %b want 1", Empty); end
   endtask

   task automatic test_pop_empty;
      do_reset();
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "pop_at_reset");
   endtask

   task automatic test_full;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue(2'b10, 16'h0000, 16'(16'h1000 + i * 16'h0101), 1'b0, "fill_push");
         if (i == 14) begin
            checks++; if (Full !== 1'b0) begin failures++; $display("FAIL full_at_32 got %b want 0", Full); end
         end
      end
      checks++; if (Full !== 1'b1 || CurrentSP !== 16'd30)
         begin failures++; $display("FAIL full_at_30 full=%b sp=%0d want 1 30", Full, CurrentSP); end
      issue(2'b10, 16'h0000, 16'hDEAD, 1'b0, "push_full");
      for (int i = 0; i < 16; i++) issue(2'b11, 16'h0000, 16'h0000, 1'b0, "drain_pop");
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "pop_drained");
   endtask

   task automatic test_store_load;
      issue(2'b01, 16'd4, 16'h1234, 1'b1, "store_4");
      issue(2'b01, 16'd8, 16'hBEEF, 1'b1, "store_8");
      issue(2'b00, 16'd4, 16'h0000, 1'b1, "load_4");
      issue(2'b00, 16'd8, 16'h0000, 1'b1, "load_8");
      issue(2'b00, 16'd4, 16'h0000, 1'b0, "reload_4");
   endtask

   task automatic test_back_to_back;
      logic [15:0] sp0;
      int n;
      do_reset();
      sp0 = sp_m;
      @(negedge Clk);
      Req = 1'b1; Op = 2'b10; WrData = 16'h5A5A;
      n = 0;
      do begin @(negedge Clk); n++; end while (!Ack && n < 8);
      checks++; if (n !== 2) begin failures++; $display("FAIL b2b_first_ack got %0d want 2", n); end
      WrData = 16'hC3C3;
      @(negedge Clk);
      checks++; if (Busy !== 1'b0 || Ack !== 1'b0)
         begin failures++; $display("FAIL b2b_idle_gap busy=%b ack=%b want 0 0", Busy, Ack); end
      @(negedge Clk);
      Req = 1'b0;
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy got %b want 1", Busy); end
      n = 0;
      do begin @(negedge Clk); n++; end while (!Ack && n < 8);
      checks++; if (n !== 1) begin failures++; $display("FAIL b2b_second_ack got %0d want 1", n); end
      checks++; if (CurrentSP !== sp0 - 16'd4) begin failures++; $display("FAIL b2b_sp got %0d want %0d", CurrentSP, sp0 - 16'd4); end
      stk.push_back(16'h5A5A);
      stk.push_back(16'hC3C3);
      sp_m = sp_m - 16'd4;
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "b2b_pop_second");
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "b2b_pop_first");
   endtask

   task automatic test_reset_abort;
      int n;
      do_reset();
      issue(2'b10, 16'h0000, 16'h1111, 1'b0, "abort_pre_push");
      @(negedge Clk);
      Req = 1'b1; Op = 2'b10; WrData = 16'h2222;
      @(negedge Clk);
      Req = 1'b0;
      checks++; if (MemRW !== 1'b1 || PushControl !== 1'b1)
         begin failures++; $display("FAIL abort_in_access rw=%b push=%b want 1 1", MemRW, PushControl); end
      #2 Rst_n = 1'b0;
      #1;
      checks++; if ({MemRW, PushControl, Busy, Ack} !== 4'b0000)
         begin failures++; $display("FAIL abort_outputs got %b want 0000", {MemRW, PushControl, Busy, Ack}); end
      checks++; if (CurrentSP !== 16'd62) begin failures++; $display("FAIL abort_sp got %0d want 62", CurrentSP); end
      @(negedge Clk);
      Rst_n = 1'b1;
      n = 0;
      repeat (3) begin @(negedge Clk); if (Ack) n++; end
      checks++; if (n !== 0 || CurrentSP !== 16'd62)
         begin failures++; $display("FAIL abort_no_ack acks=%0d sp=%0d want 0 62", n, CurrentSP); end
      model_reset();
      issue(2'b11, 16'h0000, 16'h0000, 1'b0, "abort_pop_empty");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_push_pop();
      test_pop_empty();
      test_full();
      test_store_load();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stack_port_ctrl.md
STACK_PORT_CTRL -- requirements
Module: stack_port_ctrl

Interface
REQ-001 Parameter STACK_TOP, default 16'd62: reset and empty value of the stack pointer, which is the next free word slot.
REQ-002 Parameter STACK_LIMIT, default 16'd32: lowest byte address a push may write.
REQ-003 Port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port Rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port Req, input, 1: operation request; sampled only in IDLE.
REQ-006 Port Op, input, 2: operation code; 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
REQ-007 Port ReqAddr, input, 16: byte address for LOAD and STORE.
REQ-008 Port WrData, input, 16: word for STORE and PUSH.
REQ-009 Port Ack, output, 1: one-cycle completion pulse.
REQ-010 Port Err, output, 1: valid with Ack; set when a push hits a full stack or a pop hits an empty stack.
REQ-011 Port RdData, output, 16: LOAD or POP result; valid from Ack until the next Ack.
REQ-012 Port Busy, output, 1: high in every state except IDLE.
REQ-013 Port Full, output, 1: SP < STACK_LIMIT.
REQ-014 Port Empty, output, 1: SP == STACK_TOP.
REQ-015 Port MemRW, output, 1: memory write enable; 1 = write.
REQ-016 Port PushControl, output, 1: memory stack-write select.
REQ-017 Port PopControl, output, 1: memory stack-read select.
REQ-018 Port CurrentSP, output, 16: stack byte address presented to memory.
REQ-019 Port Addr, output, 16: memory address, or the pushed word during a push.
REQ-020 Port DataIn, output, 16: store word presented to memory.
REQ-021 Port DataOut, input, 16: combinational read word returned by memory.

Function
REQ-022 Memory-side outputs SHALL be registered and SHALL be driven only in state ACCESS; in all other states MemRW, PushControl and PopControl SHALL be 0.
REQ-023 FSM states: IDLE, ACCESS, DONE.
- IDLE to ACCESS: Req=1 and the op is legal.
- IDLE to DONE: Req=1 and the op is illegal (PUSH while Full, POP while Empty); Err is set and no memory access occurs.
- ACCESS to DONE: unconditional.
- DONE to IDLE: unconditional.
REQ-024 Ack SHALL be 1 only in DONE; latency is 2 cycles from Req acceptance for a legal op and 1 cycle for an illegal op.
REQ-025 ReqAddr, WrData and Op SHALL be latched at acceptance; later input changes SHALL NOT affect the operation in flight.
REQ-026 Req while Busy=1 SHALL be ignored; Req still high in IDLE after DONE SHALL start a new operation.
REQ-027 LOAD in ACCESS SHALL drive MemRW=0 and Addr=ReqAddr, and SHALL capture RdData=DataOut at the end of ACCESS.
REQ-028 STORE in ACCESS SHALL drive MemRW=1, Addr=ReqAddr and DataIn=WrData.
REQ-029 PUSH in ACCESS SHALL drive MemRW=1, PushControl=1, CurrentSP=SP and Addr=WrData; on leaving ACCESS, SP SHALL become SP-2.
REQ-030 POP in ACCESS SHALL drive MemRW=0, PopControl=1 and CurrentSP=SP.
- Memory returns {mem[SP+3], mem[SP+2]}.
- RdData SHALL be the byte-swapped capture {DataOut[7:0], DataOut[15:8]}, so the popped word equals the word pushed.
- On leaving ACCESS, SP SHALL become SP+2.
REQ-031 SP arithmetic SHALL be 16-bit unsigned with no wrap; the Full and Empty checks guarantee SP stays within STACK_LIMIT-2 to STACK_TOP.
REQ-032 CurrentSP SHALL mirror SP whenever the block is not in ACCESS.
REQ-033 Err and RdData SHALL be left unchanged by illegal ops, except that Err is set.

Reset
REQ-034 While Rst_n=0, and immediately and asynchronously on assertion, the outputs SHALL be:
- state IDLE, SP=STACK_TOP, CurrentSP=STACK_TOP;
- MemRW, PushControl, PopControl, Ack, Err, Busy, Full = 0;
- Empty=1, Addr=0, DataIn=0, RdData=0.
REQ-035 Reset asserted mid-operation SHALL abort it, with no Ack and no SP update; a partially issued memory write is not retried.

Verification
REQ-036 Reset, then PUSH 0xA1B2: ACCESS shows MemRW=1, PushControl=1, CurrentSP=62, Addr=0xA1B2; Ack at cycle 2; SP=60; Empty=0.
REQ-037 From there, POP: CurrentSP=60, PopControl=1; RdData=0xA1B2, Ack, Err=0; SP=62; Empty=1.
REQ-038 POP at reset: Ack 1 cycle after Req with Err=1; MemRW and PopControl never assert; SP=62.
REQ-039 Push 16 words: Full=1 at SP=30; a 17th PUSH gives Ack with Err=1, no MemRW pulse, and SP stays 30.
REQ-040 STORE 0x1234 at address 4, then LOAD address 4: RdData=0x1234; Req toggled during Busy is ignored.
REQ-041 Assert Rst_n=0 during a PUSH in ACCESS: MemRW drops at once, no Ack, SP=62, Busy=0.
